// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiply datapath and its streaming back end.
// Provides matrix dimension, element widths, flattened bus widths, index width and
// the streamer state encoding.
package matrix_pkg;

    localparam int unsigned N        = 10;
    localparam int unsigned A_ELEM_W = 8;
    localparam int unsigned R_ELEM_W = 16;

    localparam int unsigned MAT_A_W  = N * N * A_ELEM_W;
    localparam int unsigned MAT_R_W  = N * N * R_ELEM_W;

    localparam int unsigned IDX_W    = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StStream
    } state_e;

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column index pair for walking an N x N matrix in row-major order.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset, clears both indices
//   clear   - synchronous clear to (0,0)
//   advance - step to the next element; (N-1,N-1) wraps to (0,0)
//   row     - current row index
//   col     - current column index
//   last    - high while the indices point at (N-1,N-1)
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int unsigned N     = matrix_pkg::N,
    parameter int unsigned IDX_W = matrix_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(N - 1);

    logic [IDX_W-1:0] row_q;
    logic [IDX_W-1:0] col_q;

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == MaxIdx) && (col_q == MaxIdx);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row_q <= '0;
            col_q <= '0;
        end else if (advance) begin
            if (col_q != MaxIdx) begin
                col_q <= col_q + IDX_W'(1);
            end else begin
                col_q <= '0;
                // Never run past the final row; the walk restarts at (0,0).
                row_q <= last ? '0 : row_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures the flattened N x N product after a settle delay and streams it out
// element by element in row-major order over a valid/ready handshake.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset, abandons any run in progress
//   start      - capture/stream request, honoured only when idle
//   result_in  - flattened product, element (i,j) at [(i*N+j)*ELEM_W +: ELEM_W]
//   busy       - high while waiting or streaming
//   out_valid  - element on out_data is valid
//   out_ready  - consumer accepts the element when high with out_valid
//   out_data   - current element
//   out_row    - row index of out_data
//   out_col    - column index of out_data
//   out_last   - high with element (N-1,N-1)
//   done       - one-cycle pulse after the final handshake
module matrix_result_streamer
    import matrix_pkg::*;
#(
    parameter int unsigned N           = matrix_pkg::N,
    parameter int unsigned ELEM_W      = matrix_pkg::R_ELEM_W,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N*N*ELEM_W-1:0] result_in,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ELEM_W-1:0]     out_data,
    output logic [IDX_W-1:0]      out_row,
    output logic [IDX_W-1:0]      out_col,
    output logic                  out_last,
    output logic                  done
);

    localparam int unsigned BitIdxW = $clog2(N * N * ELEM_W);

    state_e                state_q;
    logic [7:0]            wait_cnt_q;
    logic [N*N*ELEM_W-1:0] shadow_q;
    logic                  done_q;

    logic [IDX_W-1:0]      row;
    logic [IDX_W-1:0]      col;
    logic                  idx_last;
    logic                  idx_clear;
    logic                  idx_advance;
    logic [BitIdxW-1:0]    elem_base;

    // Capture edge also rewinds the indices to (0,0).
    assign idx_clear   = (state_q == StWait) && (wait_cnt_q == 8'd0);
    assign idx_advance = (state_q == StStream) && out_ready;

    matrix_index_counter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_index (
        .clk     (clk),
        .reset   (reset),
        .clear   (idx_clear),
        .advance (idx_advance),
        .row     (row),
        .col     (col),
        .last    (idx_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            shadow_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StWait;
                        wait_cnt_q <= 8'(WAIT_CYCLES);
                    end
                end
                StWait: begin
                    if (wait_cnt_q != 8'd0) begin
                        wait_cnt_q <= wait_cnt_q - 8'd1;
                    end else begin
                        shadow_q <= result_in;
                        state_q  <= StStream;
                    end
                end
                StStream: begin
                    if (out_ready && idx_last) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        elem_base = BitIdxW'((N * 32'(row) + 32'(col)) * ELEM_W);
    end

    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StStream);
    assign out_data  = out_valid ? shadow_q[elem_base +: ELEM_W] : '0;
    assign out_row   = row;
    assign out_col   = col;
    assign out_last  = out_valid && idx_last;
    assign done      = done_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
module tb_matrix_result_streamer;

    localparam int N  = 10;
    localparam int EW = 16;
    localparam int NE = N * N;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                out_ready;
    logic [NE*EW-1:0]    result_in;
    logic                busy, out_valid, out_last, done;
    logic [EW-1:0]       out_data;
    logic [3:0]          out_row, out_col;

    logic                start0;
    logic                ready0;
    logic [NE*EW-1:0]    result0;
    logic                busy0, valid0, last0, done0;
    logic [EW-1:0]       data0;
    logic [3:0]          row0, col0;

    int tests = 0;
    int fails = 0;

    logic [EW-1:0] exp_mat [NE];

    always #5 clk = ~clk;

    matrix_result_streamer #(
        .N           (N),
        .ELEM_W      (EW),
        .WAIT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .result_in (result_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .done      (done)
    );

    matrix_result_streamer #(
        .N           (N),
        .ELEM_W      (EW),
        .WAIT_CYCLES (0)
    ) dut_w0 (
        .clk       (clk),
        .reset     (reset),
        .start     (start0),
        .result_in (result0),
        .busy      (busy0),
        .out_valid (valid0),
        .out_ready (ready0),
        .out_data  (data0),
        .out_row   (row0),
        .out_col   (col0),
        .out_last  (last0),
        .done      (done0)
    );

    function automatic logic [NE*EW-1:0] pack_mat();
        logic [NE*EW-1:0] v;
        v = '0;
        for (int i = 0; i < NE; i++) v[i*EW +: EW] = exp_mat[i];
        return v;
    endfunction

    task automatic random_mat();
        for (int i = 0; i < NE; i++) exp_mat[i] = EW'($urandom);
        result_in = pack_mat();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Consumes the stream of the main instance against exp_mat in row-major order.
    // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready.
    // abort_after >= 0 stops after that many handshakes (no end-of-stream check).
    task automatic drain_stream(input int mode, input int abort_after, output int beats);
        int cyc;
        int p;
        bit r;
        logic [3:0] er, ec;
        logic el;
        beats = 0;
        cyc   = 0;
        p     = 0;
        while (out_valid !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL stream_start: out_valid=%b, required 1", out_valid);
            return;
        end
        while (beats < NE && cyc < 3000 && (abort_after < 0 || beats < abort_after)) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (p % 4 == 0) || (p % 4 == 3);
                default: r = ($urandom_range(0, 1) == 1);
            endcase
            p++;
            out_ready = r;
            er = 4'(beats / N);
            ec = 4'(beats % N);
            el = (beats == NE - 1);
            tests++;
            if (out_valid !== 1'b1 || out_data !== exp_mat[beats] || out_row !== er ||
                out_col !== ec || out_last !== el || done !== 1'b0) begin
                fails++;
                $display("FAIL beat%0d: valid=%b data=%h row=%0d col=%0d last=%b done=%b, required valid=1 data=%h row=%0d col=%0d last=%b done=0",
                         beats, out_valid, out_data, out_row, out_col, out_last, done,
                         exp_mat[beats], er, ec, el);
            end
            @(posedge clk); #1;
            cyc++;
            if (r) beats++;
        end
        out_ready = 1'b0;
        if (abort_after < 0) begin
            tests++;
            if (beats != NE || done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL stream_end: handshakes=%0d done=%b valid=%b busy=%b, required 100 1 0 0",
                         beats, done, out_valid, busy);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; result_in = '1;
        start0 = 1'b0; ready0 = 1'b0; result0 = '1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: busy=%b valid=%b last=%b done=%b, required all 0",
                     busy, out_valid, out_last, done);
        end
        tests++;
        if (out_data !== 16'h0 || out_row !== 4'h0 || out_col !== 4'h0) begin
            fails++;
            $display("FAIL reset_data: data=%h row=%0d col=%0d, required 0 0 0",
                     out_data, out_row, out_col);
        end
        tests++;
        if (busy0 !== 1'b0 || valid0 !== 1'b0 || done0 !== 1'b0 || data0 !== 16'h0) begin
            fails++;
            $display("FAIL reset_w0: busy=%b valid=%b done=%b data=%h, required 0 0 0 0",
                     busy0, valid0, done0, data0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_product();
        int a [N][N];
        int b [N][N];
        int s;
        int beats;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a[i][j] = i + 1;
                b[i][j] = j + 1;
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += a[i][k] * b[k][j];
                exp_mat[i*N + j] = EW'(s);
            end
        result_in = pack_mat();
        pulse_start();
        drain_stream(0, -1, beats);
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: done=%b valid=%b one cycle later, required 0 0", done, out_valid);
        end
    endtask

    task automatic test_latency();
        int beats;
        random_mat();
        pulse_start();
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL latency_wait%0d: valid=%b busy=%b, required 0 1", c, out_valid, busy);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency_valid: valid=%b after E+5, required 1", out_valid);
        end
        result_in = ~result_in;
        drain_stream(0, -1, beats);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int beats;
        random_mat();
        pulse_start();
        drain_stream(1, -1, beats);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int beats;
        random_mat();
        pulse_start();
        for (int c = 1; c <= 4; c++) begin
            start = (c == 1);
            @(posedge clk); #1;
            start = 1'b0;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL ignore_wait%0d: valid=%b, required 0", c, out_valid);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL ignore_wait_valid: valid=%b after E+5, required 1", out_valid);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_row !== 4'd0 || out_col !== 4'd0) begin
            fails++;
            $display("FAIL ignore_stream: valid=%b busy=%b row=%0d col=%0d, required 1 1 0 0",
                     out_valid, busy, out_row, out_col);
        end
        drain_stream(0, -1, beats);
        random_mat();
        pulse_start();
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL b2b_wait%0d: valid=%b busy=%b, required 0 1", c, out_valid, busy);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_valid: valid=%b after E+5, required 1", out_valid);
        end
        drain_stream(2, -1, beats);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int beats;
        bit saw_done;
        random_mat();
        pulse_start();
        drain_stream(0, 37, beats);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_row !== 4'd0 ||
            out_col !== 4'd0) begin
            fails++;
            $display("FAIL reset_mid: valid=%b busy=%b done=%b row=%0d col=%0d, required 0 0 0 0 0",
                     out_valid, busy, done, out_row, out_col);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL reset_no_done: done pulsed after abandoned stream, required never");
        end
        random_mat();
        pulse_start();
        drain_stream(2, -1, beats);
        @(posedge clk); #1;
    endtask

    task automatic test_wait_zero();
        int k;
        int cyc;
        logic [3:0] er, ec;
        logic el;
        result0 = '1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        tests++;
        if (valid0 !== 1'b0 || busy0 !== 1'b1) begin
            fails++;
            $display("FAIL w0_wait: valid=%b busy=%b, required 0 1", valid0, busy0);
        end
        @(posedge clk); #1;
        tests++;
        if (valid0 !== 1'b1) begin
            fails++;
            $display("FAIL w0_latency: valid=%b one cycle after start, required 1", valid0);
        end
        ready0 = 1'b1;
        k = 0;
        cyc = 0;
        while (k < NE && cyc < 300) begin
            er = 4'(k / N);
            ec = 4'(k % N);
            el = (k == NE - 1);
            tests++;
            if (valid0 !== 1'b1 || data0 !== 16'hFFFF || row0 !== er || col0 !== ec ||
                last0 !== el) begin
                fails++;
                $display("FAIL w0_beat%0d: valid=%b data=%h row=%0d col=%0d last=%b, required 1 ffff %0d %0d %b",
                         k, valid0, data0, row0, col0, last0, er, ec, el);
            end
            @(posedge clk); #1;
            cyc++;
            k++;
        end
        ready0 = 1'b0;
        tests++;
        if (done0 !== 1'b1 || valid0 !== 1'b0) begin
            fails++;
            $display("FAIL w0_done: done=%b valid=%b, required 1 0", done0, valid0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_product();
        test_latency();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wait_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Downstream stage of top_matrix_matrix_10x10_pipelined.
- After a start request and a fixed settle delay, captures the flattened 10x10 result matrix into a shadow register.
- Streams the 100 elements out in row-major order over a valid/ready interface, with row/column tags and a last flag.
- Decouples the wide parallel product from narrow consumers (UART/AXI-Stream bridge, checker, memory writer).

Parameters:
- N, 10, matrix dimension (rows = columns).
- ELEM_W, 16, result element width in bits.
- WAIT_CYCLES, 4, cycles to wait after start before capture; covers multiplier pipeline latency; legal range 0..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to capture and stream one result; honoured only in IDLE.
- result_in  input  N*N*ELEM_W (1600)  flattened product; element (i,j) at bits [i*N*ELEM_W + j*ELEM_W +: ELEM_W].
- busy  output  1  high in WAIT and STREAM.
- out_valid  output  1  output element valid.
- out_ready  input  1  consumer accepts the element when high together with out_valid.
- out_data  output  ELEM_W  current element.
- out_row  output  4  row index i of out_data (0..N-1).
- out_col  output  4  column index j of out_data (0..N-1).
- out_last  output  1  high with the element (N-1,N-1).
- done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (sampled high at an edge):
  - State goes to IDLE.
  - busy, out_valid, out_last, done = 0; out_data, out_row, out_col = 0; shadow register cleared.
  - Reset has priority over every other input, including mid-WAIT and mid-STREAM; a partial stream is abandoned and produces no done.
- States: IDLE, WAIT, STREAM.
- IDLE:
  - start=1 -> WAIT, wait counter loaded with WAIT_CYCLES.
  - start=0 -> stay in IDLE.
- WAIT:
  - counter != 0 -> decrement, stay.
  - counter == 0 -> capture result_in into shadow, set row=col=0, go to STREAM.
  - start is ignored.
- Latency: start sampled at edge E -> capture and out_valid rise at edge E+WAIT_CYCLES+1. WAIT_CYCLES=0 gives valid 1 cycle after start.
- STREAM:
  - out_valid=1.
  - out_data = shadow[(row*N+col)*ELEM_W +: ELEM_W].
  - out_last = (row==N-1 && col==N-1).
  - Handshake at an edge with out_valid && out_ready:
    - col<N-1 -> col+1.
    - else col=0, row+1.
    - If out_last -> go to IDLE, done=1 for exactly the next cycle, out_valid=0.
  - out_valid && !out_ready (backpressure) -> out_data, out_row, out_col, out_last held stable; no element is skipped or repeated.
  - out_ready is allowed high before out_valid; that does not count as a handshake.
- Indices: row/col are kept as separate counters (no divider). Wrap from col N-1 to 0 increments row. No wrap beyond row N-1.
- result_in is sampled only at the capture edge; later changes do not affect the stream.
- done coincides with IDLE, so start asserted during the done cycle is accepted (back-to-back runs).
- Width: out_data is a raw slice of result_in; no saturation or sign handling.

Decomposition:
- Shared package matrix_pkg:
  - N, A_ELEM_W=8, R_ELEM_W=16.
  - Flat widths MAT_A_W = N*N*A_ELEM_W and MAT_R_W = N*N*R_ELEM_W.
  - IDX_W=4.
  - State enum {IDLE, WAIT, STREAM}.
- One sub-module: matrix_index_counter.
  - Row/col counter pair with clear, advance, and a last flag.
  - Reusable by an upstream matrix loader.

Test Plan:
- A row i = i+1, B column j = j+1, product fed to result_in; start, out_ready=1 always -> 100 beats in order.
  - (0,0)=10, (2,4)=150, (9,9)=1000.
  - out_last only on beat 100; done one cycle later.
- WAIT_CYCLES=4, start at edge E -> out_valid first high after edge E+5; result_in changed at E+6 -> stream data unchanged.
- out_ready toggled 1,0,0,1 repeatedly -> every element appears exactly once, held stable while ready=0, total 100 handshakes.
- start pulsed during WAIT and STREAM -> ignored; start during the done cycle -> second run begins, first valid again after WAIT_CYCLES+1.
- reset asserted after 37 handshakes -> next cycle out_valid=0, busy=0, done never pulses; a fresh start streams from (0,0).
- WAIT_CYCLES=0, all elements 16'hFFFF -> out_valid 1 cycle after start, every out_data=65535, no truncation artefacts.
